// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths and cache-arbiter enums.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_I,
    ARB_OWN_D
  } arb_owner_t;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-cache and D-cache.
// Latches the winner's address/write line and holds the strobe until pmem_resp.
//
//   state       | meaning
//   ARB_IDLE    | no strobe; sample requests and grant
//   ARB_BUSY    | strobe driven for the latched owner until pmem_resp
//   ARB_RELEASE | one dead cycle so the owner can drop its stale request
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, last_grant_q;
  arb_op_t     op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic        i_req, d_req;
  logic        grant;
  arb_owner_t  grant_owner;
  arb_op_t     grant_op;
  logic [ADDR_W-1:0] grant_addr;
  logic        busy;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = ARB_OWN_I;
    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ARB_BUSY;
          // On a tie the D-cache wins only if the I-cache had the last grant.
          if (d_req && (!i_req || last_grant_q == ARB_OWN_I))
            grant_owner = ARB_OWN_D;
        end
      end
      ARB_BUSY: begin
        if (pmem_resp)
          state_d = ARB_RELEASE;
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // A simultaneous D read+write is treated as a write-back.
  assign grant_op   = (grant_owner == ARB_OWN_D && d_pmem_write) ? ARB_OP_WRITE : ARB_OP_READ;
  assign grant_addr = (grant_owner == ARB_OWN_D) ? d_pmem_address : i_pmem_address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_OWN_I;
      last_grant_q <= ARB_OWN_I;
      op_q         <= ARB_OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= grant_owner;
        last_grant_q <= grant_owner;
        op_q         <= grant_op;
        addr_q       <= grant_addr;
        if (grant_op == ARB_OP_WRITE)
          wdata_q <= d_pmem_wdata;
      end
    end
  end

  assign busy = (state_q == ARB_BUSY);

  assign pmem_read    = busy && (op_q == ARB_OP_READ);
  assign pmem_write   = busy && (op_q == ARB_OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp  = busy && (owner_q == ARB_OWN_I) && pmem_resp;
  assign d_pmem_resp  = busy && (owner_q == ARB_OWN_D) && pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-vector bench for cache_arbiter with hand-computed expectations.
module tb_cache_arbiter;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [LINE_W-1:0] BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LINE_W-1:0] A5   = {16{8'hA5}};
  localparam logic [LINE_W-1:0] L3C  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam logic [LINE_W-1:0] L7E  = 128'h7E7E_0000_FFFF_1111_2222_3333_4444_5555;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr);
    chk({tag, "_rd"}, pmem_read, rd);
    chk({tag, "_wr"}, pmem_write, wr);
  endtask

  task automatic chk_resps(input string tag, input logic ir, input logic dr);
    chk({tag, "_iresp"}, i_pmem_resp, ir);
    chk({tag, "_dresp"}, d_pmem_resp, dr);
  endtask

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    tick(); tick();
    chk_strobes("rst", 0, 0);
    chk_resps("rst", 0, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    rst = 1'b0;
    tick();
    chk_strobes("idle", 0, 0);

    // Single I read at 0x1230, memory answers after 5 cycles.
    i_pmem_read = 1; i_pmem_address = 16'h1230;
    tick();
    chk_strobes("i1_busy", 1, 0);
    chk("i1_addr", pmem_address, 16'h1230);
    repeat (4) tick();
    chk_strobes("i1_hold", 1, 0);
    chk_resps("i1_wait", 0, 0);
    pmem_resp = 1; pmem_rdata = BEEF;
    #1;
    chk_resps("i1_resp", 1, 0);
    chk("i1_rdata", i_pmem_rdata, BEEF);
    tick();
    pmem_resp = 0; pmem_rdata = '0;
    chk_strobes("i1_release", 0, 0);
    chk_resps("i1_release", 0, 0);
    i_pmem_read = 0;
    tick();
    chk_strobes("i1_idle", 0, 0);

    // Simultaneous I read / D write; last grant is I so D goes first.
    i_pmem_read = 1; i_pmem_address = 16'h0040;
    d_pmem_write = 1; d_pmem_address = 16'h0080; d_pmem_wdata = A5;
    tick();
    chk_strobes("tie_d", 0, 1);
    chk("tie_d_addr", pmem_address, 16'h0080);
    chk("tie_d_wdata", pmem_wdata, A5);
    pmem_resp = 1;
    #1;
    chk_resps("tie_d_resp", 0, 1);
    tick();
    pmem_resp = 0;
    d_pmem_write = 0;
    chk_strobes("tie_dead1", 0, 0);
    tick();
    chk_strobes("tie_dead2", 0, 0);
    tick();
    chk_strobes("tie_i", 1, 0);
    chk("tie_i_addr", pmem_address, 16'h0040);
    chk("tie_i_wdata_held", pmem_wdata, A5);
    pmem_resp = 1; pmem_rdata = L3C;
    #1;
    chk_resps("tie_i_resp", 1, 0);
    chk("tie_i_rdata", i_pmem_rdata, L3C);
    tick();
    pmem_resp = 0;
    i_pmem_read = 0;
    tick();

    // Latched address/wdata, plus request dropped mid-BUSY.
    d_pmem_write = 1; d_pmem_address = 16'h0100; d_pmem_wdata = L7E;
    tick();
    chk("lat_addr0", pmem_address, 16'h0100);
    d_pmem_address = 16'h0200; d_pmem_wdata = A5;
    tick();
    chk("lat_addr1", pmem_address, 16'h0100);
    chk("lat_wdata", pmem_wdata, L7E);
    d_pmem_write = 0;
    tick();
    chk_strobes("drop_hold", 0, 1);
    pmem_resp = 1;
    #1;
    chk_resps("drop_resp", 0, 1);
    tick();
    pmem_resp = 0;
    tick();

    // D read held one cycle past its resp with I pending: RELEASE absorbs it.
    d_pmem_read = 1; d_pmem_address = 16'h0300;
    tick();
    chk_strobes("held_d", 1, 0);
    chk("held_d_addr", pmem_address, 16'h0300);
    i_pmem_read = 1; i_pmem_address = 16'h0500;
    pmem_resp = 1;
    #1;
    chk_resps("held_d_resp", 0, 1);
    tick();
    pmem_resp = 0;
    chk_strobes("held_release", 0, 0);
    tick();
    d_pmem_read = 0;
    chk_strobes("held_idle", 0, 0);
    tick();
    chk_strobes("held_i", 1, 0);
    chk("held_i_addr", pmem_address, 16'h0500);
    pmem_resp = 1;
    #1;
    chk_resps("held_i_resp", 1, 0);
    tick();
    pmem_resp = 0;
    i_pmem_read = 0;
    tick();

    // Round-robin: both held for 6 grants, last grant was I -> D,I,D,I,D,I.
    i_pmem_read = 1; i_pmem_address = 16'h0A00;
    d_pmem_write = 1; d_pmem_address = 16'h0B00; d_pmem_wdata = A5;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk_strobes("rr_d", 0, 1);
        chk("rr_d_addr", pmem_address, 16'h0B00);
      end else begin
        chk_strobes("rr_i", 1, 0);
        chk("rr_i_addr", pmem_address, 16'h0A00);
      end
      pmem_resp = 1;
      #1;
      chk_resps("rr_resp", (k % 2 == 1), (k % 2 == 0));
      tick();
      pmem_resp = 0;
      chk_strobes("rr_release", 0, 0);
      tick();
    end
    i_pmem_read = 0; d_pmem_write = 0;
    tick();

    // Reset mid-BUSY on a D grant; afterwards the first tie goes to D again.
    d_pmem_read = 1; d_pmem_address = 16'h0C00;
    tick();
    chk_strobes("mid_busy", 1, 0);
    pmem_resp = 1;
    rst = 1;
    #1;
    chk_strobes("mid_rst", 0, 0);
    chk_resps("mid_rst", 0, 0);
    chk("mid_rst_addr", pmem_address, 0);
    tick();
    pmem_resp = 0;
    d_pmem_read = 0;
    rst = 0;
    tick();
    chk_strobes("post_rst_idle", 0, 0);
    i_pmem_read = 1; i_pmem_address = 16'h0D00;
    d_pmem_write = 1; d_pmem_address = 16'h0E00; d_pmem_wdata = L3C;
    tick();
    chk_strobes("post_rst_tie", 0, 1);
    chk("post_rst_addr", pmem_address, 16'h0E00);
    chk("post_rst_wdata", pmem_wdata, L3C);
    pmem_resp = 1;
    #1;
    chk_resps("post_rst_resp", 0, 1);
    tick();
    pmem_resp = 0;
    i_pmem_read = 0; d_pmem_write = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
